// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: drives the PLL reset, qualifies lock, staggers domain reset release.
// Optional macro PLL_SEQ_RETRY_LIMIT_EN builds the bounded-retry timeout handling and FAULT state.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic [2:0] dom_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    localparam int REL_CYCLES = 2 * STAGGER_CYCLES;
    localparam int SEQ_MAX    = (PLL_RST_CYCLES > REL_CYCLES) ? PLL_RST_CYCLES : REL_CYCLES;
    localparam int SEQ_W      = $clog2(SEQ_MAX + 1);
    localparam int STB_W      = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W      = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [SEQ_W-1:0] SEQ_RST_LAST = SEQ_W'(PLL_RST_CYCLES - 1);
    localparam logic [SEQ_W-1:0] SEQ_REL_LAST = SEQ_W'(REL_CYCLES - 1);
    localparam logic [SEQ_W-1:0] SEQ_STAGGER  = SEQ_W'(STAGGER_CYCLES);
    localparam logic [STB_W-1:0] STB_DONE     = STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);
`endif

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
`else
        ST_RUN       = 3'd3
`endif
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic [STB_W-1:0] r_stb_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [1:0]       r_retry;
    logic             r_pll_rst;
    logic [2:0]       r_dom_rst;
    logic             r_ready;
    logic             r_fault;

    logic             w_lock_s;
    state_t           w_state_nxt;
    logic [SEQ_W-1:0] w_seq_nxt;
    logic [STB_W-1:0] w_stb_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic [1:0]       w_retry_nxt;
    logic             w_pll_rst_nxt;
    logic [2:0]       w_dom_rst_nxt;
    logic             w_ready_nxt;
    logic             w_fault_nxt;

    assign w_lock_s = r_sync2;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // Next state and counters; counters default to zero so every state entry clears them.
    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = {SEQ_W{1'b0}};
        w_stb_nxt   = {STB_W{1'b0}};
        w_tmo_nxt   = {TMO_W{1'b0}};
        w_retry_nxt = r_retry;
        if (soft_reset) begin
            w_state_nxt = ST_RESET_PLL;
            w_retry_nxt = 2'b00;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_seq_cnt == SEQ_RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else begin
                        w_seq_nxt = r_seq_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_stb_cnt == STB_DONE) begin
                        w_state_nxt = ST_RELEASE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                        if (r_retry == RETRY_MAX) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_state_nxt = ST_RESET_PLL;
                        end
`else
                        w_state_nxt = ST_RESET_PLL;
`endif
                    end else begin
                        w_tmo_nxt = r_tmo_cnt + 1'b1;
                        if (w_lock_s) begin
                            w_stb_nxt = r_stb_cnt + 1'b1;
                        end else begin
                            w_stb_nxt = {STB_W{1'b0}};
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_RESET_PLL;
                        w_retry_nxt = 2'b00;
                    end else if (r_seq_cnt == SEQ_REL_LAST) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_seq_nxt = r_seq_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_RESET_PLL;
                        w_retry_nxt = 2'b00;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
`endif
                default: begin
                    w_state_nxt = ST_RESET_PLL;
                    w_retry_nxt = 2'b00;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with the state register.
    always_comb begin
        w_pll_rst_nxt = 1'b1;
        w_dom_rst_nxt = 3'b111;
        w_ready_nxt   = 1'b0;
        w_fault_nxt   = 1'b0;
        case (w_state_nxt)
            ST_RESET_PLL: begin
                w_pll_rst_nxt = 1'b1;
                w_dom_rst_nxt = 3'b111;
            end
            ST_WAIT_LOCK: begin
                w_pll_rst_nxt = 1'b0;
                w_dom_rst_nxt = 3'b111;
            end
            ST_RELEASE: begin
                w_pll_rst_nxt = 1'b0;
                w_dom_rst_nxt = {1'b1, (w_seq_nxt < SEQ_STAGGER), 1'b0};
            end
            ST_RUN: begin
                w_pll_rst_nxt = 1'b0;
                w_dom_rst_nxt = 3'b000;
                w_ready_nxt   = 1'b1;
            end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            ST_FAULT: begin
                w_pll_rst_nxt = 1'b1;
                w_dom_rst_nxt = 3'b111;
                w_fault_nxt   = 1'b1;
            end
`endif
            default: begin
                w_pll_rst_nxt = 1'b1;
                w_dom_rst_nxt = 3'b111;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= ST_RESET_PLL;
            r_seq_cnt <= {SEQ_W{1'b0}};
            r_stb_cnt <= {STB_W{1'b0}};
            r_tmo_cnt <= {TMO_W{1'b0}};
            r_retry   <= 2'b00;
            r_pll_rst <= 1'b1;
            r_dom_rst <= 3'b111;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seq_cnt <= w_seq_nxt;
            r_stb_cnt <= w_stb_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_retry   <= w_retry_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_dom_rst <= w_dom_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign dom_rst     = r_dom_rst;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign state       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: timeline model over the sampled lock history plus directed checks.
module tb_pll_reset_sequencer;

    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int LTC  = 64;
    localparam int STG  = 2;
    localparam int MAXR = 2;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam bit RL_EN = 1'b1;
`else
    localparam bit RL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC),
        .STAGGER_CYCLES(STG), .MAX_RETRIES(MAXR)
    ) dut (
        .refclk(clk), .rst(rst), .pll_locked(pll_locked), .soft_reset(soft_reset),
        .pll_rst(pll_rst), .dom_rst(dom_rst), .ready(ready), .fault(fault),
        .retry_count(retry_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: phase with the edge index it was entered, and the per-edge lock sample history.
    typedef struct packed {
        logic [2:0] phase;
        int         start;
        logic [1:0] retry;
    } mst_t;

    bit   hist [0:4095];
    int   m_cyc   = 0;
    bit   m_valid = 1'b0;
    mst_t m_st    = '{phase: 3'd0, start: 0, retry: 2'd0};

    function automatic mst_t model_next(input mst_t c, input int n, input bit r, input bit s);
        mst_t x = c;
        bit   ok;
        bit   ls = (n >= 2) ? hist[n-2] : 1'b0;
        if (r || s) begin
            x.phase = 3'd0; x.start = n; x.retry = 2'd0;
        end else begin
            case (c.phase)
                3'd0: if (n - c.start == PRC) begin x.phase = 3'd1; x.start = n; end
                3'd1: begin
                    // lock is qualified once LSC consecutive samples seen inside this wait are high
                    ok = (n - LSC >= c.start + 1);
                    for (int k = n - LSC - 2; k <= n - 3; k++)
                        if (k < 0 || !hist[k]) ok = 1'b0;
                    if (ok) begin
                        x.phase = 3'd2; x.start = n;
                    end else if (n - c.start == LTC) begin
                        x.start = n;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                        if (c.retry == 2'(MAXR)) x.phase = 3'd4;
                        else begin x.phase = 3'd0; x.retry = c.retry + 2'd1; end
`else
                        x.phase = 3'd0;
`endif
                    end
                end
                3'd2, 3'd3: begin
                    if (!ls) begin
                        x.phase = 3'd0; x.start = n; x.retry = 2'd0;
                    end else if (c.phase == 3'd2 && n - c.start == 2 * STG) begin
                        x.phase = 3'd3; x.start = n;
                    end
                end
                default: ;
            endcase
        end
        return x;
    endfunction

    function automatic logic [10:0] model_out(input mst_t c, input int n);
        logic       p = (c.phase == 3'd0) || (c.phase == 3'd4);
        logic [2:0] d = 3'b111;
        if (c.phase == 3'd2) d = {1'b1, (n - c.start) < STG, 1'b0};
        else if (c.phase == 3'd3) d = 3'b000;
        return {p, d, c.phase == 3'd3, c.phase == 3'd4, c.retry, c.phase};
    endfunction

    always @(posedge clk) begin
        hist[m_cyc] <= rst ? 1'b0 : pll_locked;
        m_st        <= model_next(m_st, m_cyc, rst, soft_reset);
        m_cyc       <= m_cyc + 1;
        m_valid     <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid)
            chk($sformatf("model_edge%0d", m_cyc - 1),
                int'({pll_rst, dom_rst, ready, fault, retry_count, state}),
                int'(model_out(m_st, m_cyc - 1)));
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    int rises      = 0;
    int last_rise  = 0;
    int fault_seen = 0;
    bit prev_pr    = 1'b1;

    initial begin
        rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0;
        edges(3);
        chk("rst_pll_rst", pll_rst, 1); chk("rst_dom", dom_rst, 7); chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0); chk("rst_retry", retry_count, 0); chk("rst_state", state, 0);
        rst = 1'b0;
        edges(3); chk("pll_rst_hold_e3", pll_rst, 1);
        edges(1); chk("pll_rst_fall_e4", pll_rst, 0); chk("wait_state", state, 1);
        edges(6); pll_locked = 1'b1;
        edges(10); chk("dom_e10", dom_rst, 7);
        edges(1);  chk("dom0_e11", dom_rst, 6);
        edges(2);  chk("dom1_e13", dom_rst, 4); chk("ready_e13", ready, 0);
        edges(2);  chk("dom2_e15", dom_rst, 0); chk("ready_e15", ready, 1); chk("run_state", state, 3);
        // lock loss from RUN
        edges(5); pll_locked = 1'b0;
        edges(2); chk("loss_e2_dom", dom_rst, 0); chk("loss_e2_ready", ready, 1);
        edges(1); chk("loss_e3_dom", dom_rst, 7); chk("loss_e3_ready", ready, 0);
        chk("loss_pll_rst", pll_rst, 1); chk("loss_retry", retry_count, 0);
        edges(3); chk("loss_pll_rst_4th", pll_rst, 1);
        edges(1); chk("loss_pll_rst_fall", pll_rst, 0);
        // one timeout, then a glitched lock
        edges(63); chk("to1_still_wait", state, 1);
        edges(1);  chk("to1_state", state, 0); chk("to1_retry", retry_count, RL_EN ? 1 : 0);
        edges(4);  chk("glitch_wait", state, 1); pll_locked = 1'b1;
        edges(5);  pll_locked = 1'b0;
        edges(1);  pll_locked = 1'b1;
        edges(10); chk("glitch_e10", dom_rst, 7);
        edges(1);  chk("glitch_e11", dom_rst, 6);
        edges(4);  chk("glitch_ready", ready, 1); chk("glitch_retry", retry_count, RL_EN ? 1 : 0);
        edges(3);  pll_locked = 1'b0;
        edges(3);  chk("loss2_retry_clr", retry_count, 0); chk("loss2_dom", dom_rst, 7);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        edges(68);  chk("rf_retry1", retry_count, 1); chk("rf_state1", state, 0);
        edges(68);  chk("rf_retry2", retry_count, 2); chk("rf_state2", state, 0);
        edges(67);  chk("rf_pre_fault", fault, 0); chk("rf_pre_state", state, 1);
        edges(1);   chk("rf_fault", fault, 1); chk("rf_fault_state", state, 4);
        chk("rf_fault_pll_rst", pll_rst, 1); chk("rf_fault_dom", dom_rst, 7);
        edges(10);  chk("rf_fault_sticky", fault, 1);
`else
        for (int i = 0; i < 500; i++) begin
            edges(1);
            if (fault) fault_seen++;
            if (pll_rst && !prev_pr) begin
                if (rises > 0) chk("unl_period", m_cyc - 1 - last_rise, PRC + LTC);
                rises++;
                last_rise = m_cyc - 1;
            end
            prev_pr = pll_rst;
        end
        chk("unl_no_fault", fault_seen, 0);
        chk("unl_rises", rises, 7);
`endif
        soft_reset = 1'b1;
        edges(1); soft_reset = 1'b0;
        chk("soft_fault", fault, 0); chk("soft_retry", retry_count, 0); chk("soft_state", state, 0);
        pll_locked = 1'b1;
        edges(16); chk("soft_relock_pre", ready, 0);
        edges(1);  chk("soft_relock_ready", ready, 1); chk("soft_relock_state", state, 3);
        edges(3); soft_reset = 1'b1;
        edges(1); soft_reset = 1'b0;
        chk("soft_run_state", state, 0); chk("soft_run_dom", dom_rst, 7);
        chk("soft_run_ready", ready, 0); chk("soft_run_pll_rst", pll_rst, 1);
        edges(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the video PLL's reset and lock, and orders reset release into the three PLL-clocked domains (outclk_0, outclk_1, outclk_2). It runs on the 50 MHz reference clock beside the PLL wrapper:
- drives the PLL `rst`;
- synchronizes and qualifies `locked`;
- releases per-domain resets in a staggered order;
- re-runs the sequence on lock loss, with bounded retry on lock timeout.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized lock-high cycles required (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: maximum cycles in WAIT_LOCK per attempt (> `LOCK_STABLE_CYCLES`).
- `STAGGER_CYCLES`, 8: cycles between successive domain reset releases (≥1).
- `MAX_RETRIES`, 3: timeouts tolerated before FAULT (1..3).

Ports:
- `refclk` in 1: 50 MHz reference clock; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: raw PLL `locked`, asynchronous to `refclk`.
- `soft_reset` in 1: single-cycle request to restart the sequence.
- `pll_rst` out 1: drives the PLL `rst`.
- `dom_rst` out 3: active-high reset for each domain; bit i belongs to outclk_i.
- `ready` out 1: all domains released and lock good.
- `fault` out 1: retries exhausted.
- `retry_count` out 2: timeouts in the current sequence; saturating.
- `state` out 3: debug encoding; RESET_PLL=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`; all lock decisions use `lock_s`.
- **RESET_PLL**
  - Outputs: `pll_rst`=1, `dom_rst`=3'b111.
  - Counts `PLL_RST_CYCLES` cycles, then goes to WAIT_LOCK.
- **WAIT_LOCK**
  - Outputs: `pll_rst`=0, `dom_rst`=3'b111.
  - The stable counter increments while `lock_s`=1 and clears to 0 on any `lock_s`=0.
  - Stable counter reaching `LOCK_STABLE_CYCLES`: go to RELEASE.
  - Timeout counter reaching `LOCK_TIMEOUT_CYCLES` first: a timeout.
    - If `retry_count`==`MAX_RETRIES`, go to FAULT.
    - Otherwise increment `retry_count` and go to RESET_PLL.
- **RELEASE**
  - `dom_rst[0]` drops on entry.
  - `dom_rst[1]` drops `STAGGER_CYCLES` later.
  - `dom_rst[2]` drops a further `STAGGER_CYCLES` later; the state becomes RUN on that same edge.
- **RUN**
  - Outputs: `ready`=1, `dom_rst`=0.
  - `lock_s`=0 in RELEASE or RUN (lock loss):
    - `dom_rst`=3'b111 and `ready`=0 on the next edge;
    - go to RESET_PLL;
    - `retry_count` is cleared (lock loss is not a timeout).
- **FAULT**
  - Outputs: `pll_rst`=1, `dom_rst`=3'b111, `fault`=1.
  - Exits only via `rst` or `soft_reset`.
- **Priority:** `rst` > `soft_reset` > lock loss / timeout > normal progression.
- **`soft_reset` in any state:** go to RESET_PLL, clear all counters, clear `retry_count` and `fault`.
- All counters clear on every state entry.
- Counter widths are sized by $clog2 of the respective parameter; no wrap is possible because each counter is compared for equality and then cleared.

## Timing
- **Reset values:**
  - `pll_rst`=1, `dom_rst`=3'b111, `ready`=0, `fault`=0, `retry_count`=0, `state`=RESET_PLL;
  - synchronizer flops 0, all counters 0.
- `pll_rst` falls exactly `PLL_RST_CYCLES` edges after the first edge that samples `rst`=0.
- **Lock qualification latency:** `dom_rst[0]` falls exactly 2 + `LOCK_STABLE_CYCLES` + 1 edges after the first edge that samples `pll_locked`=1 in WAIT_LOCK, provided the lock stays high.
- `dom_rst[2]` and `ready` change on the same edge.
- `ready` never asserts while any `dom_rst` bit is 1.
- **Lock loss:** `dom_rst`=3'b111 on the 3rd edge after `pll_locked` is sampled low (2 synchronizer stages plus 1 register).
- All outputs are registered.

## Configuration
- `PLL_SEQ_RETRY_LIMIT_EN` defined: timeout handling with the retry limit and FAULT state, as above.
- Undefined:
  - timeouts always return to RESET_PLL, with unlimited retries;
  - the FAULT state is not built;
  - `fault` and `retry_count` are tied to 0.

## Test plan
Parameters for all scenarios: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=64, `STAGGER_CYCLES`=2, `MAX_RETRIES`=2; macro defined.
- **Nominal bring-up.** Stimulus: `rst` high for 3 cycles, then low; `pll_locked` rises 10 cycles later and stays high. Required:
  - `pll_rst` low at edge 4;
  - `dom_rst[0]`/[1]/[2] fall 11/13/15 edges after the lock sample;
  - `ready`=1 with `dom_rst[2]`.
- **Lock glitch.** Stimulus: in WAIT_LOCK, `pll_locked` high 5 cycles, low 1, then high. Required: the stable count restarts, and `dom_rst[0]` falls 11 edges after the second rise.
- **Lock loss.** Stimulus: drop `pll_locked` in RUN. Required:
  - 3 edges later `dom_rst`=3'b111 and `ready`=0;
  - `pll_rst`=1 for 4 cycles;
  - `retry_count`=0.
- **Retry and fault.** Stimulus: `pll_locked` held 0. Required:
  - three timeouts, each 64 cycles in WAIT_LOCK;
  - `retry_count` goes 1, then 2;
  - on the third timeout `fault`=1, `state`=4, `pll_rst`=1.
- **soft_reset out of FAULT.** Stimulus: pulse `soft_reset` in FAULT. Required: next edge `fault`=0, `retry_count`=0, `state`=0; a later good lock reaches RUN.
- **Macro undefined.** Stimulus: `pll_locked`=0 for 500 cycles. Required: `fault` never asserts, and `pll_rst` pulses every 68 cycles (4 reset + 64 wait).
